loom_clk_ctrl: RTL and testbench
================================

Name: loom_clk_ctrl

Overview:
- Run/stop/step controller that produces the clock-enable for the emulation clock gate. Its ce_o drives the gate's ce input.
- Runs on the free-running clock, i.e. the same clock the gate receives as input.
- Accepts host commands (STOP, RUN, STEP N) over a valid/ready handshake.
- Halts on a breakpoint trigger and counts enabled (DUT) cycles.

Parameters:
- CntWidth, 32, width of step count cmd_count_i.
- CycleWidth, 64, width of enabled-cycle counter cycle_cnt_o.
- RunAtReset, 1, 1 = state RUNNING and ce_o=1 during/after reset, so the DUT is clocked during reset; 0 = STOPPED.

Ports:
- clk_i  in  1  free-running clock.
- rst_ni  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_op_i  in  2  0=STOP, 1=RUN, 2=STEP, 3=reserved (accepted, no effect).
- cmd_count_i  in  CntWidth  step count for STEP.
- trig_en_i  in  1  breakpoint enable.
- trig_i  in  1  breakpoint trigger (level, sampled each cycle).
- ce_o  out  1  clock enable to gate, registered.
- running_o  out  1  state != STOPPED.
- stepping_o  out  1  state == STEPPING.
- step_done_o  out  1  one-cycle pulse when a STEP completes normally.
- trig_hit_o  out  1  sticky: stopped by trigger.
- cycle_cnt_o  out  CycleWidth  number of cycles with ce_o=1.

Behaviour:
- States: STOPPED, RUNNING, STEPPING. The state register, ce_o, the remaining-step counter, trig_hit_o, step_done_o and cycle_cnt_o are all flops.
- Reset (rst_ni=0 at edge), all outputs take their reset values:
  - state = RUNNING if RunAtReset, else STOPPED; ce_o = RunAtReset.
  - step_done_o = 0, trig_hit_o = 0, cycle_cnt_o = 0, remaining = 0.
  - Reset mid-step aborts the step with no step_done_o pulse.
- Invariant: ce_o = 1 exactly when state is RUNNING or STEPPING.
- Handshake and trigger condition:
  - A command is accepted when cmd_valid_i && cmd_ready_o.
  - fire = trig_en_i && trig_i && state != STOPPED.
  - cmd_ready_o = (state != STEPPING) && !fire. This is combinational.
- Command latency: a command accepted at edge t takes effect at edge t, so the new ce_o is visible in cycle t+1.
- STOP: next state STOPPED. Accepted in any state where ready is high; no-op if already STOPPED.
- RUN: next state RUNNING; clears trig_hit_o.
- STEP N:
  - Clears trig_hit_o.
  - N>0: state STEPPING, remaining=N. ce_o is high for exactly N consecutive cycles (t+1..t+N), then low at t+N+1 with state STOPPED. step_done_o is high in cycle t+N+1 only.
  - N=0: state STOPPED, ce_o=0 from t+1, step_done_o pulses in t+1.
- STEP accepted while RUNNING: the run is replaced by the N-cycle step.
- STEPPING decrement: remaining decrements each cycle; on the cycle where remaining==1, next state is STOPPED and step_done_o is set.
- Trigger:
  - On fire, next state is STOPPED, ce_o=0 next cycle and trig_hit_o is set.
  - Trigger beats a step's final cycle: no step_done_o pulse.
  - No command is accepted in a fire cycle.
  - trig_i is ignored in STOPPED.
  - trig_hit_o stays set until the next accepted RUN/STEP or reset.
- cycle_cnt_o: increments by 1 on every edge where ce_o==1, i.e. it equals the number of DUT clock edges delivered. Wraps modulo 2^CycleWidth silently. Cleared only by reset.
- Reserved op 3: accepted, with no state change.

Test Plan:
- Reset with RunAtReset=1, release, hold 10 cycles -> ce_o=1 throughout, running_o=1, cycle_cnt_o=10, cmd_ready_o=1.
- STOP accepted at t, then STEP N=5 accepted at t+3 -> ce_o=0 from t+1; ce_o=1 for cycles t+4..t+8; ce_o=0 at t+9 with step_done_o=1 for that cycle only; cycle_cnt_o advanced by exactly 5; cmd_ready_o=0 during t+4..t+8.
- STEP N=0 from STOPPED -> ce_o stays 0, step_done_o pulses next cycle, cycle_cnt_o unchanged.
- RUN, then trig_en_i=1 with trig_i=1 in cycle k while cmd_valid_i=1 (op=STOP) -> cmd_ready_o=0 in k; ce_o=0 from k+1; trig_hit_o=1; next RUN accepted clears trig_hit_o and ce_o=1 one cycle later.
- STEP N=3 with trig_i pulsed (trig_en_i=1) in the 2nd enabled cycle -> exactly 2 enabled cycles, no step_done_o, trig_hit_o=1.
- STEP N=100 then rst_ni=0 at the 10th enabled cycle -> next cycle: state matches RunAtReset, cycle_cnt_o=0, no step_done_o. Repeat with RunAtReset=0 -> ce_o=0, running_o=0.

Source files
------------

// File: rtl/loom_clk_ctrl.sv
// Run/stop/step controller driving the clock-enable of the emulation clock gate.
// Runs on the free-running clock; halts on breakpoint trigger and counts enabled cycles.
module loom_clk_ctrl #(
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned CycleWidth = 64,
  parameter bit          RunAtReset = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [CntWidth-1:0]   cmd_count_i,
  input  logic                  trig_en_i,
  input  logic                  trig_i,
  output logic                  ce_o,
  output logic                  running_o,
  output logic                  stepping_o,
  output logic                  step_done_o,
  output logic                  trig_hit_o,
  output logic [CycleWidth-1:0] cycle_cnt_o
);

  typedef enum logic [1:0] {StStopped, StRunning, StStepping} state_e;

  localparam logic [1:0] OpStop = 2'd0;
  localparam logic [1:0] OpRun  = 2'd1;
  localparam logic [1:0] OpStep = 2'd2;

  localparam logic [CntWidth-1:0]   CntZero  = '0;
  localparam logic [CntWidth-1:0]   CntOne   = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CycleWidth-1:0] CycZero  = '0;
  localparam state_e                StReset  = RunAtReset ? StRunning : StStopped;

  state_e                state_q;
  logic                  ce_q;
  logic                  step_done_q;
  logic                  trig_hit_q;
  logic [CntWidth-1:0]   remaining_q;
  logic [CycleWidth-1:0] cycle_cnt_q;

  logic fire;
  logic accept;

  assign fire        = trig_en_i && trig_i && (state_q != StStopped);
  assign cmd_ready_o = (state_q != StStepping) && !fire;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StReset;
      ce_q        <= RunAtReset;
      step_done_q <= 1'b0;
      trig_hit_q  <= 1'b0;
      remaining_q <= CntZero;
      cycle_cnt_q <= CycZero;
    end else begin
      step_done_q <= 1'b0;
      // Counts DUT edges actually delivered; wraps silently.
      cycle_cnt_q <= cycle_cnt_q + {{(CycleWidth-1){1'b0}}, ce_q};
      if (fire) begin
        state_q     <= StStopped;
        ce_q        <= 1'b0;
        trig_hit_q  <= 1'b1;
        remaining_q <= CntZero;
      end else if (accept) begin
        unique case (cmd_op_i)
          OpStop: begin
            state_q <= StStopped;
            ce_q    <= 1'b0;
          end
          OpRun: begin
            state_q    <= StRunning;
            ce_q       <= 1'b1;
            trig_hit_q <= 1'b0;
          end
          OpStep: begin
            trig_hit_q <= 1'b0;
            if (cmd_count_i != CntZero) begin
              state_q     <= StStepping;
              ce_q        <= 1'b1;
              remaining_q <= cmd_count_i;
            end else begin
              state_q     <= StStopped;
              ce_q        <= 1'b0;
              step_done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (state_q == StStepping) begin
        if (remaining_q == CntOne) begin
          state_q     <= StStopped;
          ce_q        <= 1'b0;
          step_done_q <= 1'b1;
          remaining_q <= CntZero;
        end else begin
          remaining_q <= remaining_q - CntOne;
        end
      end
    end
  end

  assign ce_o        = ce_q;
  assign running_o   = (state_q != StStopped);
  assign stepping_o  = (state_q == StStepping);
  assign step_done_o = step_done_q;
  assign trig_hit_o  = trig_hit_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Directed bench for loom_clk_ctrl: expectations queued per edge, compared after the edge.
module tb_loom_clk_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_count_i;
  logic        trig_en_i;
  logic        trig_i;

  logic        cmd_ready_o, ce_o, running_o, stepping_o, step_done_o, trig_hit_o;
  logic [63:0] cycle_cnt_o;
  logic        cmd_ready0, ce0, running0, stepping0, step_done0, trig_hit0;
  logic [63:0] cycle_cnt0;

  always #5 clk_i = ~clk_i;

  loom_clk_ctrl #(.CntWidth(32), .CycleWidth(64), .RunAtReset(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_count_i(cmd_count_i), .trig_en_i(trig_en_i), .trig_i(trig_i),
    .ce_o(ce_o), .running_o(running_o), .stepping_o(stepping_o), .step_done_o(step_done_o),
    .trig_hit_o(trig_hit_o), .cycle_cnt_o(cycle_cnt_o)
  );

  loom_clk_ctrl #(.CntWidth(32), .CycleWidth(64), .RunAtReset(1'b0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready0),
    .cmd_op_i(cmd_op_i), .cmd_count_i(cmd_count_i), .trig_en_i(trig_en_i), .trig_i(trig_i),
    .ce_o(ce0), .running_o(running0), .stepping_o(stepping0), .step_done_o(step_done0),
    .trig_hit_o(trig_hit0), .cycle_cnt_o(cycle_cnt0)
  );

  localparam int SelCe = 0, SelRun = 1, SelStepping = 2, SelDone = 3, SelHit = 4;
  localparam int SelCnt = 5, SelCe0 = 6, SelRun0 = 7, SelCnt0 = 8;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_ce;
  logic [63:0] m_cnt;

  function automatic logic [63:0] observe(int sel);
    case (sel)
      SelCe:       return {63'd0, ce_o};
      SelRun:      return {63'd0, running_o};
      SelStepping: return {63'd0, stepping_o};
      SelDone:     return {63'd0, step_done_o};
      SelHit:      return {63'd0, trig_hit_o};
      SelCnt:      return cycle_cnt_o;
      SelCe0:      return {63'd0, ce0};
      SelRun0:     return {63'd0, running0};
      SelCnt0:     return cycle_cnt0;
      default:     return 64'hdead;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int sel, logic [63:0] exp);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = exp;
    sb.push_back(c);
  endtask

  task automatic edge_and_compare();
    chk_t c;
    @(posedge clk_i);
    #1;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      check(c.tag, observe(c.sel), c.exp);
    end
  endtask

  // Advance one edge; ce_after/sd are the expected values for the following cycle.
  task automatic tick(string tag, logic ce_after, logic sd);
    if (m_ce) m_cnt = m_cnt + 64'd1;
    m_ce = ce_after;
    push({tag, ".ce"}, SelCe, {63'd0, ce_after});
    push({tag, ".running"}, SelRun, {63'd0, ce_after});
    push({tag, ".step_done"}, SelDone, {63'd0, sd});
    push({tag, ".cnt"}, SelCnt, m_cnt);
    edge_and_compare();
  endtask

  task automatic ready_now(string tag, logic exp);
    #1;
    check({tag, ".ready"}, {63'd0, cmd_ready_o}, {63'd0, exp});
  endtask

  task automatic do_reset(string tag);
    rst_ni = 1'b0;
    push({tag, ".ce"}, SelCe, 64'd1);
    push({tag, ".running"}, SelRun, 64'd1);
    push({tag, ".step_done"}, SelDone, 64'd0);
    push({tag, ".trig_hit"}, SelHit, 64'd0);
    push({tag, ".cnt"}, SelCnt, 64'd0);
    push({tag, ".ce0"}, SelCe0, 64'd0);
    push({tag, ".running0"}, SelRun0, 64'd0);
    push({tag, ".cnt0"}, SelCnt0, 64'd0);
    edge_and_compare();
    rst_ni = 1'b1;
    m_ce  = 1'b1;
    m_cnt = 64'd0;
  endtask

  task automatic send(logic [1:0] op, logic [31:0] cnt);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_count_i = cnt;
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'd0;
    cmd_count_i = 32'd0;
    trig_en_i   = 1'b0;
    trig_i      = 1'b0;
    m_ce        = 1'b1;
    m_cnt       = 64'd0;
    @(posedge clk_i);
    do_reset("rst1");

    // Free run after reset for 10 cycles.
    for (int i = 0; i < 10; i++) tick("run10", 1'b1, 1'b0);
    check("run10.cnt_final", cycle_cnt_o, 64'd10);
    ready_now("run10", 1'b1);

    // Reserved op is accepted with no effect.
    send(2'd3, 32'd0);
    ready_now("rsvd", 1'b1);
    tick("rsvd", 1'b1, 1'b0);

    // STOP, then STEP 5 three cycles later.
    send(2'd0, 32'd0);
    ready_now("stop", 1'b1);
    tick("stop", 1'b0, 1'b0);
    cmd_valid_i = 1'b0;
    tick("stop_idle1", 1'b0, 1'b0);
    tick("stop_idle2", 1'b0, 1'b0);
    send(2'd2, 32'd5);
    push("step5.stepping", SelStepping, 64'd1);
    tick("step5.c1", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;
    ready_now("step5.c1", 1'b0);
    for (int i = 2; i <= 5; i++) begin
      tick("step5.cN", 1'b1, 1'b0);
      ready_now("step5.cN", 1'b0);
    end
    push("step5.stepping_end", SelStepping, 64'd0);
    tick("step5.done", 1'b0, 1'b1);
    tick("step5.after", 1'b0, 1'b0);

    // STEP 0 from STOPPED.
    send(2'd2, 32'd0);
    tick("step0", 1'b0, 1'b1);
    cmd_valid_i = 1'b0;
    tick("step0.after", 1'b0, 1'b0);

    // RUN, then trigger in a cycle that also presents STOP.
    send(2'd1, 32'd0);
    tick("run", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;
    tick("run.c2", 1'b1, 1'b0);
    trig_en_i = 1'b1;
    trig_i    = 1'b1;
    send(2'd0, 32'd0);
    ready_now("fire", 1'b0);
    push("fire.trig_hit", SelHit, 64'd1);
    tick("fire", 1'b0, 1'b0);
    cmd_valid_i = 1'b0;
    trig_i      = 1'b0;
    push("sticky.trig_hit", SelHit, 64'd1);
    tick("sticky", 1'b0, 1'b0);
    trig_i = 1'b1;
    ready_now("trig_stopped", 1'b1);
    tick("trig_stopped", 1'b0, 1'b0);
    trig_i = 1'b0;
    send(2'd1, 32'd0);
    push("rerun.trig_hit", SelHit, 64'd0);
    tick("rerun", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;

    // STEP 3 replacing the run; trigger in the 2nd enabled cycle.
    send(2'd2, 32'd3);
    tick("step3.c1", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;
    tick("step3.c2", 1'b1, 1'b0);
    trig_i = 1'b1;
    push("step3.trig_hit", SelHit, 64'd1);
    tick("step3.fire", 1'b0, 1'b0);
    trig_i = 1'b0;
    tick("step3.after", 1'b0, 1'b0);

    // Trigger on the final cycle of a STEP 2 suppresses step_done.
    send(2'd2, 32'd2);
    push("step2.trig_clr", SelHit, 64'd0);
    tick("step2.c1", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;
    tick("step2.c2", 1'b1, 1'b0);
    trig_i = 1'b1;
    push("step2.trig_hit", SelHit, 64'd1);
    tick("step2.fire", 1'b0, 1'b0);
    trig_i    = 1'b0;
    trig_en_i = 1'b0;
    tick("step2.after", 1'b0, 1'b0);

    // STEP 100 aborted by reset at the 10th enabled cycle.
    send(2'd2, 32'd100);
    tick("step100.c1", 1'b1, 1'b0);
    cmd_valid_i = 1'b0;
    for (int i = 2; i <= 10; i++) tick("step100.cN", 1'b1, 1'b0);
    do_reset("rst2");
    tick("post_rst", 1'b1, 1'b0);
    tick("post_rst2", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
